// File: rtl/mips_multicycle.sv
// Multi-cycle MIPS subset core: one shared memory port for fetch and data,
// 32x32 register file, FETCH/DECODE/EXEC/MEM/WB/HALT sequencing.
module mips_multicycle #(
  parameter int          ADDR_W   = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] pc_out,
  output logic [31:0]       alu_out,
  output logic              halted
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       ir_q, ir_d, a_q, a_d, b_q, b_d, mdr_q, mdr_d, alu_q, alu_d;
  logic [31:0]       rf_q [32];

  logic              rf_we;
  logic [4:0]        rf_waddr;
  logic [31:0]       rf_wdata;

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm16;
  logic [31:0] sext_imm, pc_ext, pc_inc, br_target, j_target, r_result;
  logic        supported;

  assign opcode = ir_q[31:26];
  assign rs     = ir_q[25:21];
  assign rt     = ir_q[20:16];
  assign rd     = ir_q[15:11];
  assign funct  = ir_q[5:0];
  assign imm16  = ir_q[15:0];

  // Address math is done at 32 bits and truncated, so narrow ADDR_W wraps cleanly.
  assign sext_imm  = {{16{imm16[15]}}, imm16};
  assign pc_ext    = 32'(pc_q);
  assign pc_inc    = pc_ext + 32'd4;
  assign br_target = pc_ext + {sext_imm[29:0], 2'b00};
  assign j_target  = {pc_ext[31:28], ir_q[25:0], 2'b00};

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    supported = 1'b0;
    case (opcode)
      OP_RTYPE: supported = funct inside {FN_ADDU, FN_SUBU, FN_AND, FN_OR, FN_SLT};
      OP_J, OP_BEQ, OP_ORI, OP_LUI, OP_LW, OP_SW: supported = 1'b1;
      default: supported = 1'b0;
    endcase
  end

  always_comb begin
    r_result = 32'd0;
    case (funct)
      FN_ADDU: r_result = a_q + b_q;
      FN_SUBU: r_result = a_q - b_q;
      FN_AND:  r_result = a_q & b_q;
      FN_OR:   r_result = a_q | b_q;
      FN_SLT:  r_result = {31'd0, $signed(a_q) < $signed(b_q)};
      default: r_result = 32'd0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    a_d      = a_q;
    b_d      = b_q;
    mdr_d    = mdr_q;
    alu_d    = alu_q;
    rf_we    = 1'b0;
    rf_waddr = rt;
    rf_wdata = alu_q;
    case (state_q)
      S_FETCH: if (mem_ready) begin
        ir_d    = mem_rdata;
        pc_d    = pc_inc[ADDR_W-1:0];
        state_d = S_DECODE;
      end
      S_DECODE: begin
        a_d     = (rs == 5'd0) ? 32'd0 : rf_q[rs];
        b_d     = (rt == 5'd0) ? 32'd0 : rf_q[rt];
        state_d = supported ? S_EXEC : S_HALT;
      end
      S_EXEC: begin
        state_d = S_WB;
        case (opcode)
          OP_RTYPE: alu_d = r_result;
          OP_ORI:   alu_d = a_q | {16'd0, imm16};
          OP_LUI:   alu_d = {imm16, 16'd0};
          OP_LW, OP_SW: begin
            alu_d   = a_q + sext_imm;
            state_d = S_MEM;
          end
          OP_BEQ: begin
            if (a_q == b_q) pc_d = br_target[ADDR_W-1:0];
            state_d = S_FETCH;
          end
          OP_J: begin
            pc_d    = j_target[ADDR_W-1:0];
            state_d = S_FETCH;
          end
          default: state_d = S_HALT;
        endcase
      end
      S_MEM: if (mem_ready) begin
        if (opcode == OP_SW) begin
          state_d = S_FETCH;
        end else begin
          mdr_d   = mem_rdata;
          state_d = S_WB;
        end
      end
      S_WB: begin
        rf_waddr = (opcode == OP_RTYPE) ? rd : rt;
        rf_wdata = (opcode == OP_LW) ? mdr_q : alu_q;
        rf_we    = (rf_waddr != 5'd0);
        state_d  = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_HALT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC[ADDR_W-1:0];
      ir_q    <= 32'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      mdr_q   <= 32'd0;
      alu_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      mdr_q   <= mdr_d;
      alu_q   <= alu_d;
    end
  end

  // NOTE: the register file is reset, which forces it into flops rather than a RAM macro.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= 32'd0;
    end else if (rf_we) begin
      rf_q[rf_waddr] <= rf_wdata;
    end
  end

  // rst_n gates the request so it drops the instant reset asserts.
  assign mem_req   = rst_n && ((state_q == S_FETCH) || (state_q == S_MEM));
  assign mem_we    = mem_req && (state_q == S_MEM) && (opcode == OP_SW);
  assign mem_addr  = (state_q == S_MEM) ? {alu_q[ADDR_W-1:2], 2'b00} : pc_q;
  assign mem_wdata = b_q;
  assign pc_out    = pc_q;
  assign alu_out   = alu_q;
  assign halted    = (state_q == S_HALT);

endmodule

// File: tb/tb_mips_multicycle.sv
// Directed bench for mips_multicycle: small programs run from a word memory model,
// outputs sampled on the falling edge against hand-computed values.
module tb_mips_multicycle;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_req, mem_we, mem_ready, halted;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_out, alu_out;
  logic [31:0] mem [0:4095];
  int          edges;
  int          n_tests = 0;
  int          n_fail  = 0;

  mips_multicycle #(.ADDR_W(32), .RESET_PC(32'h0000_3000)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .pc_out    (pc_out),
    .alu_out   (alu_out),
    .halted    (halted)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[13:2]];

  always @(posedge clk) begin
    if (mem_req && mem_we && mem_ready) mem[mem_addr[13:2]] <= mem_wdata;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edges <= 0;
    else        edges <= edges + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to the falling edge that follows the given number of rising edges since reset.
  task automatic run_to(input int target);
    while (edges < target) @(negedge clk);
  endtask

  task automatic put(input logic [31:0] addr, input logic [31:0] data);
    mem[addr[13:2]] = data;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    rst_n     = 1'b0;
    mem_ready = 1'b1;
    for (int i = 0; i < 4096; i++) mem[i] = 32'd0;
    put(32'h3000, 32'h3401_1234); // ori  $1,$0,0x1234
    put(32'h3004, 32'h0021_1021); // addu $2,$1,$1
    put(32'h3008, 32'hAC02_0004); // sw   $2,4($0)
    put(32'h300C, 32'h8C03_0004); // lw   $3,4($0)
    put(32'h3010, 32'h0060_2021); // addu $4,$3,$0
    put(32'h3014, 32'h0021_0021); // addu $0,$1,$1
    put(32'h3018, 32'h0001_2821); // addu $5,$0,$1
    put(32'h301C, 32'h0022_3023); // subu $6,$1,$2
    put(32'h3020, 32'h00C1_382A); // slt  $7,$6,$1
    put(32'h3024, 32'h3C08_ABCD); // lui  $8,0xABCD
    put(32'h3028, 32'h0022_4824); // and  $9,$1,$2
    put(32'h302C, 32'h0022_5025); // or   $10,$1,$2
    put(32'h3030, 32'h1020_0005); // beq  $1,$0,+5 (not taken)
    put(32'h3034, 32'h0800_0C0F); // j    0x303C
    put(32'h3038, 32'hFC00_0000); // unsupported, skipped by j
    put(32'h303C, 32'h1021_FFFF); // beq  $1,$1,-1 (self loop)

    #12;
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_mem_we",  {31'd0, mem_we},  32'd0);
    check("rst_pc",      pc_out,           32'h3000);
    check("rst_alu",     alu_out,          32'd0);
    check("rst_halted",  {31'd0, halted},  32'd0);

    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("first_fetch_req",  {31'd0, mem_req}, 32'd1);
    check("first_fetch_addr", mem_addr,         32'h3000);

    run_to(4);
    check("ori_4cyc_addr", mem_addr, 32'h3004);
    run_to(7);
    check("addu_wb_noreq", {31'd0, mem_req}, 32'd0);
    check("addu_alu",      alu_out,          32'h0000_2468);
    run_to(8);
    check("addu_8cyc_addr", mem_addr, 32'h3008);
    check("addu_pc",        pc_out,   32'h3008);

    run_to(11);
    check("sw_req",   {31'd0, mem_req}, 32'd1);
    check("sw_we",    {31'd0, mem_we},  32'd1);
    check("sw_addr",  mem_addr,         32'h4);
    check("sw_wdata", mem_wdata,        32'h2468);
    run_to(12);
    check("sw_mem",       mem[1],   32'h2468);
    check("sw_4cyc_addr", mem_addr, 32'h300C);

    run_to(15);
    check("lw_req",  {31'd0, mem_req}, 32'd1);
    check("lw_we",   {31'd0, mem_we},  32'd0);
    check("lw_addr", mem_addr,         32'h4);
    mem_ready = 1'b0;
    for (int c = 16; c <= 18; c++) begin
      run_to(c);
      check("lw_wait_addr", mem_addr,         32'h4);
      check("lw_wait_req",  {31'd0, mem_req}, 32'd1);
      check("lw_wait_we",   {31'd0, mem_we},  32'd0);
    end
    mem_ready = 1'b1;
    run_to(19);
    check("lw_wb_noreq", {31'd0, mem_req}, 32'd0);
    run_to(20);
    check("lw_8cyc_addr", mem_addr, 32'h3010);

    run_to(24);
    check("r3_loaded", alu_out, 32'h2468);
    run_to(28);
    check("addu_r0_addr", mem_addr, 32'h3018);
    run_to(32);
    check("r0_stays_zero", alu_out, 32'h1234);
    run_to(36);
    check("subu_wrap", alu_out, 32'hFFFF_EDCC);
    run_to(40);
    check("slt_signed", alu_out, 32'd1);
    run_to(44);
    check("lui", alu_out, 32'hABCD_0000);
    run_to(48);
    check("and", alu_out, 32'h0000_0020);
    run_to(52);
    check("or",      alu_out,  32'h0000_367C);
    check("or_addr", mem_addr, 32'h3030);

    run_to(55);
    check("beq_not_taken", mem_addr, 32'h3034);
    run_to(58);
    check("j_target", mem_addr, 32'h303C);
    run_to(61);
    check("beq_loop1", mem_addr, 32'h303C);
    run_to(62);
    check("beq_decode_noreq", {31'd0, mem_req}, 32'd0);
    run_to(64);
    check("beq_loop2_addr", mem_addr, 32'h303C);
    check("beq_loop2_pc",   pc_out,   32'h303C);

    #2;
    rst_n = 1'b0;
    #1;
    check("rst2_req", {31'd0, mem_req}, 32'd0);
    check("rst2_pc",  pc_out,           32'h3000);
    check("rst2_alu", alu_out,          32'd0);
    put(32'h3000, 32'h8C01_0000); // lw $1,0($0)
    put(32'h3004, 32'hFC00_0000); // opcode 0x3F
    @(negedge clk);
    rst_n = 1'b1;

    run_to(3);
    check("lw2_mem_req", {31'd0, mem_req}, 32'd1);
    check("lw2_addr",    mem_addr,         32'h0);
    mem_ready = 1'b0;
    run_to(5);
    #2;
    rst_n = 1'b0;
    #1;
    check("midmem_rst_req", {31'd0, mem_req}, 32'd0);
    check("midmem_rst_we",  {31'd0, mem_we},  32'd0);
    check("midmem_rst_pc",  pc_out,           32'h3000);
    @(negedge clk);
    rst_n     = 1'b1;
    mem_ready = 1'b1;
    #1;
    check("resume_req",  {31'd0, mem_req}, 32'd1);
    check("resume_addr", mem_addr,         32'h3000);

    run_to(5);
    check("lw2_done_addr", mem_addr, 32'h3004);
    run_to(7);
    check("halt_flag",  {31'd0, halted},  32'd1);
    check("halt_noreq", {31'd0, mem_req}, 32'd0);
    run_to(12);
    check("halt_stays", {31'd0, halted},  32'd1);
    check("halt_req",   {31'd0, mem_req}, 32'd0);
    check("halt_pc",    pc_out,           32'h3008);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
